// File: rtl/la_pkg.sv
// -----------------------------------------------------------------------------
// la_pkg
// Shared definitions for the logic-analyzer configuration receiver:
//   - rx_state_t      : UART byte-receiver state encoding
//   - LA_FRAME_LEN    : bytes per command frame (4 config bytes + checksum)
//   - LA_CHECKSUM     : required mod-256 sum of every byte in a frame
//   - SEL_MSB/ARM_BIT/TRIGEN_BIT : bit positions inside smptm
// -----------------------------------------------------------------------------
package la_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam int         LA_FRAME_LEN = 5;
  localparam logic [7:0] LA_CHECKSUM  = 8'hAA;

  // smptm field layout: [SEL_MSB:0] clock select, [ARM_BIT] arm,
  // [TRIGEN_BIT] trigger enable.
  localparam int SEL_MSB    = 4;
  localparam int ARM_BIT    = 5;
  localparam int TRIGEN_BIT = 6;

endpackage

// File: rtl/la_uart_byte_rx.sv
// -----------------------------------------------------------------------------
// la_uart_byte_rx
// Oversampled 8N1 UART byte receiver with a 2-flop input synchroniser.
// Ports:
//   i_clk         system clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_rx          raw RX pin (idle high, asynchronous)
//   o_data        last received byte (valid while o_byte_valid is high)
//   o_byte_valid  one-cycle strobe: byte accepted (stop bit high)
//   o_frame_err   one-cycle strobe: stop bit sampled low
//   o_start       one-cycle strobe: start edge detected in IDLE
//   o_busy        high in START/DATA/STOP
// -----------------------------------------------------------------------------
module la_uart_byte_rx
  import la_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_byte_valid,
  output logic       o_frame_err,
  output logic       o_start,
  output logic       o_busy
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t     r_state;
  rx_state_t     w_state_next;
  logic          r_meta;
  logic          r_sync;
  logic          r_sync_d;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_byte_valid;
  logic          r_frame_err;
  logic          w_fall;
  logic          w_cnt_zero;
  logic          w_start;

  // Only a genuine 1->0 transition starts a byte. After a framing error the
  // FSM drops straight back to IDLE; a line held low produces no edge, so
  // reception implicitly waits for the line to return high.
  assign w_fall     = r_sync_d & ~r_sync;
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta   <= 1'b1;
      r_sync   <= 1'b1;
      r_sync_d <= 1'b1;
      r_state  <= RX_IDLE;
    end else begin
      r_meta   <= i_rx;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
      r_state  <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    unique case (r_state)
      RX_IDLE: begin
        if (w_fall) begin
          w_state_next = RX_START;
          w_start      = 1'b1;
        end
      end
      // Line back high at mid start bit means a glitch: silently abandon.
      RX_START: if (w_cnt_zero) w_state_next = r_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_cnt_zero && (r_bit_idx == 3'd7)) w_state_next = RX_STOP;
      RX_STOP:  if (w_cnt_zero) w_state_next = RX_IDLE;
      default:  w_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      // Half-bit first so every later sample lands mid-bit.
      if (w_start) begin
        r_cnt <= HALF_BIT;
      end else if (r_state != RX_IDLE) begin
        r_cnt <= w_cnt_zero ? FULL_BIT : r_cnt - 1'b1;
      end
      if (r_state == RX_START) begin
        r_bit_idx <= '0;
      end else if ((r_state == RX_DATA) && w_cnt_zero) begin
        r_bit_idx <= r_bit_idx + 1'b1;
        r_shift   <= {r_sync, r_shift[7:1]};
      end
      if ((r_state == RX_STOP) && w_cnt_zero) begin
        r_byte_valid <= r_sync;
        r_frame_err  <= ~r_sync;
      end
    end
  end

  assign o_data       = r_shift;
  assign o_byte_valid = r_byte_valid;
  assign o_frame_err  = r_frame_err;
  assign o_start      = w_start;
  assign o_busy       = (r_state != RX_IDLE);

endmodule

// File: rtl/la_cfg_uart_rx.sv
// -----------------------------------------------------------------------------
// la_cfg_uart_rx
// Receives 5-byte command frames over UART, validates the mod-256 checksum and
// atomically applies the four capture-core configuration registers.
// Ports:
//   freq_in    system clock (12 MHz), rising edge
//   rst_n      asynchronous active-low reset
//   uartrx     raw UART RX pin, idle high
//   smptm      [4:0] clock select, [5] arm, [6] trigger enable
//   ynltm      readout delay count
//   trgv1      trigger edge mask
//   trgv2      trigger value
//   cfg_valid  one-cycle pulse when a new configuration is applied
//   cfg_err    one-cycle pulse on checksum/framing error or timeout discard
//   uarxled    high while a byte is being received
//   err_cnt    saturating error counter (only with LA_CFG_ERRCNT_EN defined)
// Build option: define LA_CFG_ERRCNT_EN to add the err_cnt output.
// -----------------------------------------------------------------------------
module la_cfg_uart_rx
  import la_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 104,
  parameter int         FRAME_LEN    = LA_FRAME_LEN,
  parameter logic [7:0] CHECKSUM     = LA_CHECKSUM,
  parameter int         TIMEOUT_BITS = 20
) (
  input  logic       freq_in,
  input  logic       rst_n,
  input  logic       uartrx,
  output logic [7:0] smptm,
  output logic [7:0] ynltm,
  output logic [7:0] trgv1,
  output logic [7:0] trgv2,
  output logic       cfg_valid,
  output logic       cfg_err,
  output logic       uarxled
`ifdef LA_CFG_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam int            IW     = $clog2(FRAME_LEN);
  localparam logic [IW-1:0] LAST   = IW'(FRAME_LEN - 1);
  localparam int            TO_LIM = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int            TW     = $clog2(TO_LIM + 1);

  logic [7:0]    w_byte;
  logic          w_byte_valid;
  logic          w_frame_err;
  logic          w_start;
  logic          w_busy;
  logic [IW-1:0] r_idx;
  logic [7:0]    r_sum;
  logic [TW-1:0] r_to_cnt;
  logic [7:0]    r_smptm, r_ynltm, r_trgv1, r_trgv2;
  logic          r_cfg_valid;
  logic          r_cfg_err;
  logic [7:0]    w_sum_next;
  logic          w_counting;
  logic          w_to_expire;

  la_uart_byte_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_rx (
    .i_clk       (freq_in),
    .i_rst_n     (rst_n),
    .i_rx        (uartrx),
    .o_data      (w_byte),
    .o_byte_valid(w_byte_valid),
    .o_frame_err (w_frame_err),
    .o_start     (w_start),
    .o_busy      (w_busy)
  );

  assign w_sum_next  = r_sum + w_byte;
  // Idle time is measured from the last accepted byte of a partial frame.
  assign w_counting  = !w_busy && (r_idx != '0);
  assign w_to_expire = w_counting && (r_to_cnt == TW'(TO_LIM - 1));

  // Config bytes 0..3; the checksum byte only feeds the running sum.
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_buf
    logic [7:0] r_byte;
    always_ff @(posedge freq_in or negedge rst_n) begin
      if (!rst_n) begin
        r_byte <= '0;
      end else if (w_byte_valid && !w_to_expire && (r_idx == IW'(gi))) begin
        r_byte <= w_byte;
      end
    end
  end

  always_ff @(posedge freq_in or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_sum       <= '0;
      r_to_cnt    <= '0;
      r_smptm     <= '0;
      r_ynltm     <= '0;
      r_trgv1     <= '0;
      r_trgv2     <= '0;
      r_cfg_valid <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_valid <= 1'b0;
      r_cfg_err   <= 1'b0;

      if (w_start || w_byte_valid || !w_counting || w_to_expire) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end

      // Timeout has priority over a coincident start edge: the partial frame
      // is dropped and the incoming byte becomes byte 0 of a new frame.
      if (w_to_expire || w_frame_err) begin
        r_cfg_err <= 1'b1;
        r_idx     <= '0;
        r_sum     <= '0;
      end else if (w_byte_valid) begin
        if (r_idx == LAST) begin
          r_idx <= '0;
          r_sum <= '0;
          if (w_sum_next == CHECKSUM) begin
            r_cfg_valid <= 1'b1;
            r_smptm     <= g_buf[0].r_byte;
            r_ynltm     <= g_buf[1].r_byte;
            r_trgv1     <= g_buf[2].r_byte;
            r_trgv2     <= g_buf[3].r_byte;
          end else begin
            r_cfg_err <= 1'b1;
          end
        end else begin
          r_idx <= r_idx + 1'b1;
          r_sum <= w_sum_next;
        end
      end
    end
  end

  assign smptm     = r_smptm;
  assign ynltm     = r_ynltm;
  assign trgv1     = r_trgv1;
  assign trgv2     = r_trgv2;
  assign cfg_valid = r_cfg_valid;
  assign cfg_err   = r_cfg_err;
  assign uarxled   = w_busy;

`ifdef LA_CFG_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge freq_in or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (r_cfg_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule
